// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI serial-clock / frame controller.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      RUN   = 2'd2,
      TRAIL = 2'd3
   } state_e;

   // SPI mode encodings, {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Data-path strobes for one SCLK edge, returned as {read, write}.
   // cpha=0 presents bit 0 from the LEAD phase, so the final trailing edge has nothing left to shift.
   function automatic logic [1:0] edge_strobes(input logic cpha, input logic leading, input logic last);
      if (!cpha) begin
         return {leading, ~leading & ~last};
      end
      return {~leading, leading};
   endfunction

endpackage

// File: rtl/spi_sclk_ctrl_if.sv
// Control/status bundle between the CPU-side registers and the SCLK/frame controller.
interface spi_sclk_ctrl_if #(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned LEN_W = 6
);
   logic             start;
   logic [DIV_W-1:0] div;
   logic [LEN_W-1:0] frame_len;
   logic             cpol;
   logic             cpha;
   logic             SCLK;
   logic             SCLK_pulse;
   logic             read;
   logic             write;
   logic             cs_n;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] bit_idx;

   modport master (
      output start, div, frame_len, cpol, cpha,
      input  SCLK, SCLK_pulse, read, write, cs_n, busy, done, bit_idx
   );

   modport slave (
      input  start, div, frame_len, cpol, cpha,
      output SCLK, SCLK_pulse, read, write, cs_n, busy, done, bit_idx
   );
endinterface

// File: rtl/clk_tick_div.sv
// Loadable half-period tick counter: counts 0..term and flags the terminal cycle.
module clk_tick_div #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             clr,
   input  logic             en,
   output logic             tc
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] term_q, term_d;

   // Equality compare against the terminal value, so an all-ones divider never overflows.
   assign tc = en && (cnt_q == term_q);

   // Next count: clear wins, otherwise count and wrap on terminal count.
   always_comb begin
      term_d = load ? load_val : term_q;
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == term_q) ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter and terminal-value registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         term_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
      end
   end

endmodule

// File: rtl/spi_sclk_ctrl.sv
// Programmable-rate SCLK generator with CS framing and sample/shift strobes, all SPI modes.
module spi_sclk_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned DIV_W = 16,
   parameter int unsigned LEN_W = 6
) (
   input logic            clk,
   input logic            reset,
   spi_sclk_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             cpol_q, cpol_d;
   logic             cpha_q, cpha_d;
   logic [LEN_W:0]   e_q, e_d;
   logic             sclk_q, sclk_d;
   logic             pulse_q, pulse_d;
   logic             read_q, read_d;
   logic             write_q, write_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LEN_W-1:0] bit_idx_q, bit_idx_d;

   logic             tc;
   logic             accept;
   logic             fire;
   logic             last_edge;
   logic [LEN_W:0]   e_last;

   assign accept    = (state_q == IDLE) && bus.start && (bus.frame_len != '0);
   // The LEAD terminal count is itself edge 0, so LEAD and RUN both fire SCLK edges.
   assign fire      = tc && ((state_q == LEAD) || (state_q == RUN));
   assign e_last    = {len_q, 1'b0} - 1'b1;
   assign last_edge = (e_q == e_last);

   clk_tick_div #(.DIV_W(DIV_W)) u_tick (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (bus.div),
      .clr      (accept),
      .en       (state_q != IDLE),
      .tc       (tc)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: each non-idle phase advances on the shared tick counter's terminal count.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)            state_d = LEAD;
         LEAD:    if (tc)                state_d = RUN;
         RUN:     if (tc && last_edge)   state_d = TRAIL;
         TRAIL:   if (tc)                state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // Output and frame-context next values; every output is registered from these.
   always_comb begin
      len_d     = len_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      e_d       = e_q;
      sclk_d    = sclk_q;
      pulse_d   = 1'b0;
      read_d    = 1'b0;
      write_d   = 1'b0;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bit_idx_d = (state_q == IDLE) ? '0 : e_q[LEN_W:1];

      unique case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            if (accept) begin
               len_d   = bus.frame_len;
               cpol_d  = bus.cpol;
               cpha_d  = bus.cpha;
               e_d     = '0;
               sclk_d  = bus.cpol;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               write_d = ~bus.cpha;
            end
         end
         TRAIL: begin
            if (tc) begin
               cs_n_d = 1'b1;
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (fire) begin
         sclk_d            = ~sclk_q;
         pulse_d           = 1'b1;
         {read_d, write_d} = edge_strobes(cpha_q, ~e_q[0], last_edge);
         if (!last_edge) begin
            e_d = e_q + 1'b1;
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q     <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         e_q       <= '0;
         sclk_q    <= 1'b0;
         pulse_q   <= 1'b0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bit_idx_q <= '0;
      end else begin
         len_q     <= len_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         e_q       <= e_d;
         sclk_q    <= sclk_d;
         pulse_q   <= pulse_d;
         read_q    <= read_d;
         write_q   <= write_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   assign bus.SCLK       = sclk_q;
   assign bus.SCLK_pulse = pulse_q;
   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.cs_n       = cs_n_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.bit_idx    = bit_idx_q;

endmodule
